// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the two-port register-file writeback arbiter
// and its destination-register scoreboard.
package rf_wb_arbiter_pkg;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 16;
    localparam int NUM_REQ  = 2;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [NUM_REGS-1:0] busy_t;
    typedef logic [NUM_REQ-1:0]  reqVec_t;

    // Identity of the requester that most recently won the write port.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } reqId_e;

    function automatic busy_t addrOneHot(input addr_t a);
        busy_t oh;
        oh    = '0;
        oh[a] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of requester, issue-reservation and register-file write signals;
// the arbiter uses the slave view, the surrounding pipeline the master view.
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic  req0_valid;
    addr_t req0_addr;
    data_t req0_data;
    logic  req0_ready;

    logic  req1_valid;
    addr_t req1_addr;
    data_t req1_data;
    logic  req1_ready;

    logic  issue_valid;
    addr_t issue_addr;
    logic  issue_ready;

    addr_t rf_addr3;
    data_t rf_data3;
    logic  rf_write;
    busy_t busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output issue_valid, issue_addr,
        input  issue_ready,
        input  rf_addr3, rf_data3, rf_write, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  issue_valid, issue_addr,
        output issue_ready,
        output rf_addr3, rf_data3, rf_write, busy
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, contention goes to
// whoever did not win the last actual transfer.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic    clk,
    input  logic    reset,
    input  reqVec_t valid_i,
    output reqVec_t grant_o
);

    // Resetting to the other requester makes FIRST_PRIO win the first contention.
    localparam reqId_e RESET_LAST = (FIRST_PRIO == 0) ? REQ1 : REQ0;

    reqId_e lastGrant_q;
    reqId_e lastGrant_d;

    always_comb begin
        grant_o = '0;
        if (!reset) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = (lastGrant_q == REQ0) ? 2'b10 : 2'b01;
                default: grant_o = '0;
            endcase
        end
    end

    // Grants are only issued to valid requesters, so any grant is a transfer.
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (grant_o[0]) begin
            lastGrant_d = REQ0;
        end else if (grant_o[1]) begin
            lastGrant_d = REQ1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q <= RESET_LAST;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: merges ALU and load writebacks onto one register-file
// write port and tracks registers reserved by issue until their write lands.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic            clk,
    input  logic            reset,
    rf_wb_arbiter_if.slave  bus
);

    reqVec_t grant;
    logic    reservation;
    busy_t   busySet;
    busy_t   busyClr;

    logic    rfWrite_q, rfWrite_d;
    addr_t   rfAddr_q,  rfAddr_d;
    data_t   rfData_q,  rfData_d;
    busy_t   busy_q,    busy_d;

    rr_arb2 #(
        .FIRST_PRIO (FIRST_PRIO)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_i ({bus.req1_valid, bus.req0_valid}),
        .grant_o (grant)
    );

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.issue_ready = !reset && !busy_q[bus.issue_addr];
    assign reservation     = bus.issue_valid && bus.issue_ready;

    // Address/data hold their last written values when no transfer occurs.
    always_comb begin
        rfWrite_d = |grant;
        rfAddr_d  = rfAddr_q;
        rfData_d  = rfData_q;
        if (grant[0]) begin
            rfAddr_d = bus.req0_addr;
            rfData_d = bus.req0_data;
        end else if (grant[1]) begin
            rfAddr_d = bus.req1_addr;
            rfData_d = bus.req1_data;
        end
    end

    // Clear follows the registered write; a same-edge reservation wins.
    always_comb begin
        busySet = reservation ? addrOneHot(bus.issue_addr) : '0;
        busyClr = rfWrite_q   ? addrOneHot(rfAddr_q)       : '0;
        busy_d  = (busy_q & ~busyClr) | busySet;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rfWrite_q <= 1'b0;
            rfAddr_q  <= '0;
            rfData_q  <= '0;
            busy_q    <= '0;
        end else begin
            rfWrite_q <= rfWrite_d;
            rfAddr_q  <= rfAddr_d;
            rfData_q  <= rfData_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rf_write = rfWrite_q;
    assign bus.rf_addr3 = rfAddr_q;
    assign bus.rf_data3 = rfData_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then random traffic,
// checked against a behavioural model of grant priority and the busy scoreboard.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int FIRST_PRIO = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(
        .FIRST_PRIO (FIRST_PRIO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    wr_t expQ[$];

    // Model: index of the requester granted most recently, and per-register reservations.
    int  mLast;
    bit  mBusy [4];
    bit  mPendValid;
    int  mPendAddr;
    bit  modelKnown = 1'b0;
    bit  acc0, acc1;

    bit          p0v, p1v;
    logic [1:0]  p0a, p1a;
    logic [15:0] p0d, p1d;

    logic [15:0] shadowRf [4];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle: compare combinational outputs and busy, then advance the model across the next edge.
    task automatic checkOutput();
        int         g;
        bit         expIssueReady;
        logic [3:0] expBusy;
        wr_t        w;
        if (reset)                             g = -1;
        else if (bus.req0_valid && bus.req1_valid) g = 1 - mLast;
        else if (bus.req0_valid)               g = 0;
        else if (bus.req1_valid)               g = 1;
        else                                   g = -1;

        expIssueReady = reset ? 1'b0 : !mBusy[bus.issue_addr];
        checkVal("req0_ready", {31'd0, bus.req0_ready}, {31'd0, g == 0});
        checkVal("req1_ready", {31'd0, bus.req1_ready}, {31'd0, g == 1});
        checkVal("issue_ready", {31'd0, bus.issue_ready}, {31'd0, expIssueReady});
        if (modelKnown) begin
            for (int i = 0; i < 4; i++) expBusy[i] = mBusy[i];
            checkVal("busy", {28'd0, bus.busy}, {28'd0, expBusy});
        end

        acc0 = (g == 0);
        acc1 = (g == 1);

        if (reset) begin
            mLast      = (FIRST_PRIO == 0) ? 1 : 0;
            for (int i = 0; i < 4; i++) mBusy[i] = 1'b0;
            mPendValid = 1'b0;
            modelKnown = 1'b1;
        end else begin
            if (mPendValid) mBusy[mPendAddr] = 1'b0;
            if (bus.issue_valid && expIssueReady) mBusy[bus.issue_addr] = 1'b1;
            mPendValid = (g >= 0);
            if (g >= 0) begin
                w.addr    = (g == 0) ? bus.req0_addr : bus.req1_addr;
                w.data    = (g == 0) ? bus.req0_data : bus.req1_data;
                mPendAddr = int'(w.addr);
                mLast     = g;
                expQ.push_back(w);
            end
        end
    endtask

    task automatic applyStimulus(input bit rst,
                                 input bit v0, input logic [1:0] a0, input logic [15:0] d0,
                                 input bit v1, input logic [1:0] a1, input logic [15:0] d1,
                                 input bit iv, input logic [1:0] ia);
        reset           = rst;
        bus.req0_valid  = v0;
        bus.req0_addr   = a0;
        bus.req0_data   = d0;
        bus.req1_valid  = v1;
        bus.req1_addr   = a1;
        bus.req1_data   = d1;
        bus.issue_valid = iv;
        bus.issue_addr  = ia;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic applyPending(input bit rst, input bit iv, input logic [1:0] ia);
        applyStimulus(rst, p0v, p0a, p0d, p1v, p1a, p1d, iv, ia);
        if (acc0) p0v = 1'b0;
        if (acc1) p1v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0);
    endtask

    // Monitor: pop one expected write for every rf_write pulse; otherwise outputs must hold.
    initial begin : monitor
        bit          monitorOn;
        logic        rstS;
        logic [1:0]  holdAddr;
        logic [15:0] holdData;
        wr_t         w;
        monitorOn = 1'b0;
        holdAddr  = '0;
        holdData  = '0;
        forever begin
            @(posedge clk);
            rstS = reset;
            #2;
            if (rstS === 1'b1) begin
                monitorOn = 1'b1;
                holdAddr  = '0;
                holdData  = '0;
                checkVal("rst_rf_write", {31'd0, bus.rf_write}, 32'd0);
                checkVal("rst_rf_addr3", {30'd0, bus.rf_addr3}, 32'd0);
                checkVal("rst_rf_data3", {16'd0, bus.rf_data3}, 32'd0);
                expQ.delete();
            end else if (monitorOn) begin
                if (bus.rf_write === 1'b1) begin
                    shadowRf[bus.rf_addr3] = bus.rf_data3;
                    if (expQ.size() == 0) begin
                        checkVal("unexpected_write", {31'd0, bus.rf_write}, 32'd0);
                    end else begin
                        w = expQ.pop_front();
                        checkVal("rf_addr3", {30'd0, bus.rf_addr3}, {30'd0, w.addr});
                        checkVal("rf_data3", {16'd0, bus.rf_data3}, {16'd0, w.data});
                        holdAddr = w.addr;
                        holdData = w.data;
                    end
                end else begin
                    checkVal("rf_write", {31'd0, bus.rf_write}, {31'd0, expQ.size() != 0});
                    if (expQ.size() != 0) void'(expQ.pop_front());
                    checkVal("hold_rf_addr3", {30'd0, bus.rf_addr3}, {30'd0, holdAddr});
                    checkVal("hold_rf_data3", {16'd0, bus.rf_data3}, {16'd0, holdData});
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 4; i++) shadowRf[i] = 16'hxxxx;
        p0v = 1'b0; p1v = 1'b0;
        p0a = '0;   p1a = '0;
        p0d = '0;   p1d = '0;
        #1;

        // Reset with requesters knocking: nothing may be granted.
        repeat (2) applyStimulus(1'b1, 1'b1, 2'd1, 16'h1111, 1'b1, 2'd2, 16'h2222, 1'b1, 2'd0);
        idle(1);

        // Single ALU writeback right after reset.
        applyStimulus(1'b0, 1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(2);

        // Fresh reset, then continuous contention: grants alternate starting with FIRST_PRIO.
        applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0);
        p0v = 1'b1; p0a = 2'd0; p0d = 16'hA000;
        p1v = 1'b1; p1a = 2'd3; p1d = 16'hB000;
        repeat (6) begin
            applyPending(1'b0, 1'b0, 2'd0);
            if (!p0v) begin p0v = 1'b1; p0d = p0d + 16'd1; end
            if (!p1v) begin p1v = 1'b1; p1d = p1d + 16'd1; end
        end
        p0v = 1'b0; p1v = 1'b0;
        idle(2);

        // Same-address contention: both writes land back to back, the later one sticks.
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd0, 16'h0F0F, 1'b0, 2'd0);
        p0v = 1'b1; p0a = 2'd1; p0d = 16'hAAAA;
        p1v = 1'b1; p1a = 2'd1; p1d = 16'h5555;
        repeat (2) applyPending(1'b0, 1'b0, 2'd0);
        idle(2);
        checkVal("reg1_final", {16'd0, shadowRf[1]}, 32'h5555);

        // Reserve r3, write it, then reserve r3 again on the edge that clears it.
        idle(1);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd3, 16'h3333, 1'b0, 2'd0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 2'd3, 16'h4444, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd3);
        idle(2);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd3, 16'h3030, 1'b0, 2'd0);
        idle(2);

        // Reset while a write is on the port and r1/r2 are reserved.
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h0BAD, 1'b0, 2'd0, 16'd0, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd2, 16'hDEAD, 1'b1, 2'd1, 16'hBEEF, 1'b1, 2'd0);
        idle(2);

        // Idle gaps between lone requests must not disturb priority.
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h0001, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h0002, 1'b1, 2'd1, 16'h0003, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h0002, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd2, 16'h0004, 1'b0, 2'd0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 2'd3, 16'h0005, 1'b1, 2'd2, 16'h0006, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd2, 16'h0006, 1'b0, 2'd0);
        idle(2);

        // Random traffic with requesters holding until accepted and occasional resets.
        p0v = 1'b0; p1v = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!p0v && $urandom_range(0, 99) < 60) begin
                p0v = 1'b1;
                p0a = 2'($urandom_range(0, 3));
                p0d = 16'($urandom);
            end
            if (!p1v && $urandom_range(0, 99) < 60) begin
                p1v = 1'b1;
                p1a = 2'($urandom_range(0, 3));
                p1d = 16'($urandom);
            end
            applyPending($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
                         2'($urandom_range(0, 3)));
        end
        p0v = 1'b0; p1v = 1'b0;
        idle(3);
        checkVal("queue_drained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
